uart_link_buffer: RTL and testbench

- Parametrised successor to the game's byte-level UART pass-through block; sits between the UART RX/TX byte engines and the game logic (ship placement and shot exchange).
- Buffers received and to-be-sent bytes in independent FIFOs with valid/ready handshakes on the application side.
- Supports runtime loopback (RX bytes re-sent on TX), registered monitor taps, and sticky overflow flags.

---
 rtl/uart_link_buffer_pkg.sv | 17 +
 rtl/uart_link_buffer_if.sv | 34 +++
 rtl/uart_link_buffer_fifo.sv | 62 ++++++
 rtl/uart_link_buffer.sv | 130 +++++++++++++
 tb/tb_uart_link_buffer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_link_buffer_pkg.sv
// Shared definitions for the UART link buffer.
//   DEFAULT_DATA_W / DEFAULT_DEPTH : default byte width and FIFO depth
//   level_w()                      : width of an occupancy count 0..depth
//   LOOPBACK_ON                    : loopback_enable value selecting loopback
package uart_link_buffer_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  localparam logic LOOPBACK_ON = 1'b1;

  // One extra bit so that a completely full FIFO (level == depth) fits.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_link_buffer_if.sv
// Handshake bundle between the UART byte engines, the game logic and the
// link buffer.
//   rx_*     : byte strobe from the UART receiver (no backpressure)
//   tx_*     : byte stream to the UART transmitter
//   app_rx_* : received bytes offered to the game logic
//   app_tx_* : bytes offered by the game logic for transmission
// Modport slave is the buffer's view, master is the surrounding logic's view.
interface uart_link_buffer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] app_rx_data;
  logic              app_rx_valid;
  logic              app_rx_ready;
  logic [DATA_W-1:0] app_tx_data;
  logic              app_tx_valid;
  logic              app_tx_ready;

  modport slave (
    input  rx_data, rx_valid, tx_ready, app_rx_ready, app_tx_data, app_tx_valid,
    output tx_data, tx_valid, app_rx_data, app_rx_valid, app_tx_ready
  );

  modport master (
    output rx_data, rx_valid, tx_ready, app_rx_ready, app_tx_data, app_tx_valid,
    input  tx_data, tx_valid, app_rx_data, app_rx_valid, app_tx_ready
  );

endinterface

// File: rtl/uart_link_buffer_fifo.sv
// link_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (accepted when not full, or full but popping)
//   pop        : drop the head entry (ignored when empty)
//   head       : current head entry, 0 while empty
//   full/empty : occupancy flags
//   level      : occupancy 0..DEPTH
module link_fifo
  import uart_link_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int LVL_W  = level_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers carry one extra MSB: equal pointers mean empty, pointers that
  // differ only in the MSB mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can still go ahead.
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_link_buffer.sv
// uart_link_buffer: byte buffering between the UART RX/TX engines and the
// game logic, with runtime loopback, monitor taps and a sticky overflow flag.
//   pclk, rst_n      : clock, asynchronous active-low reset
//   loopback_enable  : 1 = RX FIFO contents are moved into the TX FIFO
//   clear_flags      : pulse clearing rx_overflow and statistics
//   bus (slave)      : rx/tx/app_rx/app_tx handshakes
//   rx_monitor       : last byte pushed into the RX FIFO
//   tx_monitor       : last byte popped to the transmitter
//   rx_level/tx_level: FIFO occupancies
//   rx_overflow      : sticky, a receive strobe was dropped
//   rx_byte_cnt/tx_byte_cnt : statistics, live only with UART_LINK_STATS_EN
//                             defined, otherwise tied to 0
module uart_link_buffer
  import uart_link_buffer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int CNT_W  = 16,
  parameter int LVL_W  = level_w(DEPTH)
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 loopback_enable,
  input  logic                 clear_flags,
  uart_link_buffer_if.slave    bus,
  output logic [DATA_W-1:0]    rx_monitor,
  output logic [DATA_W-1:0]    tx_monitor,
  output logic [LVL_W-1:0]     rx_level,
  output logic [LVL_W-1:0]     tx_level,
  output logic                 rx_overflow,
  output logic [CNT_W-1:0]     rx_byte_cnt,
  output logic [CNT_W-1:0]     tx_byte_cnt
);

  logic              lb;
  logic [DATA_W-1:0] rx_head;
  logic [DATA_W-1:0] tx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              tx_full;
  logic              tx_empty;
  logic              rx_push;
  logic              rx_pop;
  logic              tx_push;
  logic              tx_pop;
  logic              move;
  logic [DATA_W-1:0] tx_push_data;

  assign lb = (loopback_enable == LOOPBACK_ON);

  assign tx_pop = bus.tx_ready && !tx_empty;

  // Loopback mover: a TX slot is available if TX is not full or its head is
  // leaving this same cycle.
  assign move = lb && !rx_empty && (!tx_full || tx_pop);

  assign rx_pop  = lb ? move : (bus.app_rx_ready && !rx_empty);
  assign rx_push = bus.rx_valid && (!rx_full || rx_pop);

  // app_tx_ready is forced low in loopback, so an app byte can never collide
  // with a moved byte on the single TX push port.
  assign bus.app_tx_ready = !lb && !tx_full;
  assign tx_push      = lb ? move : (bus.app_tx_valid && bus.app_tx_ready);
  assign tx_push_data = lb ? rx_head : bus.app_tx_data;

  assign bus.app_rx_valid = !lb && !rx_empty;
  assign bus.app_rx_data  = rx_head;
  assign bus.tx_valid     = !tx_empty;
  assign bus.tx_data      = tx_head;

  link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_rx_fifo (
    .clk       (pclk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (bus.rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_tx_fifo (
    .clk       (pclk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_monitor <= '0;
      tx_monitor <= '0;
    end else begin
      if (rx_push) rx_monitor <= bus.rx_data;
      if (tx_pop)  tx_monitor <= tx_head;
    end
  end

  // Clear takes priority over a same-cycle drop.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)                                  rx_overflow <= 1'b0;
    else if (clear_flags)                        rx_overflow <= 1'b0;
    else if (bus.rx_valid && rx_full && !rx_pop) rx_overflow <= 1'b1;
  end

`ifdef UART_LINK_STATS_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte_cnt <= '0;
      tx_byte_cnt <= '0;
    end else if (clear_flags) begin
      rx_byte_cnt <= '0;
      tx_byte_cnt <= '0;
    end else begin
      if (rx_push) rx_byte_cnt <= rx_byte_cnt + 1'b1;
      if (tx_pop)  tx_byte_cnt <= tx_byte_cnt + 1'b1;
    end
  end
`else
  assign rx_byte_cnt = '0;
  assign tx_byte_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_link_buffer.sv
// Self-checking bench for uart_link_buffer: directed table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_uart_link_buffer;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int LW = 5;
  localparam int CW = 16;

  logic pclk = 1'b0;
  logic rst_n = 1'b1;
  logic loopback_enable;
  logic clear_flags;
  logic [W-1:0]  rx_monitor, tx_monitor;
  logic [LW-1:0] rx_level, tx_level;
  logic          rx_overflow;
  logic [CW-1:0] rx_byte_cnt, tx_byte_cnt;

  uart_link_buffer_if #(.DATA_W(W)) bus ();

  uart_link_buffer #(.DATA_W(W), .DEPTH(D), .CNT_W(CW)) dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .loopback_enable (loopback_enable),
    .clear_flags     (clear_flags),
    .bus             (bus),
    .rx_monitor      (rx_monitor),
    .tx_monitor      (tx_monitor),
    .rx_level        (rx_level),
    .tx_level        (tx_level),
    .rx_overflow     (rx_overflow),
    .rx_byte_cnt     (rx_byte_cnt),
    .tx_byte_cnt     (tx_byte_cnt)
  );

  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] rxq[$];
  logic [W-1:0] txq[$];
  logic [W-1:0] m_rxmon, m_txmon;
  bit           m_ovf;
  int           m_rxcnt, m_txcnt;

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_rxmon = '0;
    m_txmon = '0;
    m_ovf   = 1'b0;
    m_rxcnt = 0;
    m_txcnt = 0;
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    bit lb, tpop, app_push, move, rpop;
    int rs, ts;
    logic [W-1:0] b;
    lb       = loopback_enable;
    rs       = rxq.size();
    ts       = txq.size();
    tpop     = bus.tx_ready && ts > 0;
    app_push = !lb && bus.app_tx_valid && ts < D;
    move     = lb && rs > 0 && (ts < D || tpop);
    rpop     = lb ? move : (bus.app_rx_ready && rs > 0);
    if (tpop) begin
      m_txmon = txq.pop_front();
      m_txcnt = (m_txcnt + 1) % 65536;
    end
    if (rpop) begin
      b = rxq.pop_front();
      if (move) txq.push_back(b);
    end
    if (app_push) txq.push_back(bus.app_tx_data);
    if (bus.rx_valid) begin
      if (rxq.size() < D) begin
        rxq.push_back(bus.rx_data);
        m_rxmon = bus.rx_data;
        m_rxcnt = (m_rxcnt + 1) % 65536;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (clear_flags) begin
      m_ovf   = 1'b0;
      m_rxcnt = 0;
      m_txcnt = 0;
    end
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic check_model(string tag);
    bit lb;
    bit arv, tv;
    lb  = loopback_enable;
    arv = !lb && rxq.size() > 0;
    tv  = txq.size() > 0;
    chk({tag, " rx_level"},     32'(rx_level),         32'(rxq.size()));
    chk({tag, " tx_level"},     32'(tx_level),         32'(txq.size()));
    chk({tag, " app_rx_valid"}, 32'(bus.app_rx_valid), 32'(arv));
    if (arv) chk({tag, " app_rx_data"}, 32'(bus.app_rx_data), 32'(rxq[0]));
    chk({tag, " tx_valid"},     32'(bus.tx_valid),     32'(tv));
    if (tv) chk({tag, " tx_data"}, 32'(bus.tx_data), 32'(txq[0]));
    chk({tag, " app_tx_ready"}, 32'(bus.app_tx_ready), 32'(!lb && txq.size() < D));
    chk({tag, " rx_monitor"},   32'(rx_monitor),       32'(m_rxmon));
    chk({tag, " tx_monitor"},   32'(tx_monitor),       32'(m_txmon));
    chk({tag, " rx_overflow"},  32'(rx_overflow),      32'(m_ovf));
`ifdef UART_LINK_STATS_EN
    chk({tag, " rx_byte_cnt"},  32'(rx_byte_cnt),      32'(m_rxcnt));
    chk({tag, " tx_byte_cnt"},  32'(tx_byte_cnt),      32'(m_txcnt));
`else
    chk({tag, " rx_byte_cnt"},  32'(rx_byte_cnt),      32'(0));
    chk({tag, " tx_byte_cnt"},  32'(tx_byte_cnt),      32'(0));
`endif
  endtask

  // One clock edge: model advances with the inputs, outputs sampled 1 ns later.
  task automatic step();
    model_edge();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;
    bus.app_rx_ready = 1'b0;
    bus.app_tx_valid = 1'b0;
    bus.app_tx_data  = '0;
    bus.tx_ready     = 1'b0;
    loopback_enable  = 1'b0;
    clear_flags      = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic rxv; logic [7:0] rxd; logic arr; logic atv; logic [7:0] atd;
    logic txr; logic lb; logic clr;
    logic e_arv; logic [7:0] e_ard; int e_rlvl;
    logic e_tv;  logic [7:0] e_td;  int e_tlvl;
    logic e_ovf; logic [7:0] e_rmon; logic [7:0] e_tmon;
  } vec_t;

  vec_t tbl[12];

  initial begin
    string t;
    idle();
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset rx_level", 32'(rx_level), 0);
    chk("reset tx_level", 32'(tx_level), 0);
    chk("reset app_rx_valid", 32'(bus.app_rx_valid), 0);
    chk("reset tx_valid", 32'(bus.tx_valid), 0);
    chk("reset tx_data", 32'(bus.tx_data), 0);
    chk("reset app_rx_data", 32'(bus.app_rx_data), 0);
    chk("reset monitors", 32'({rx_monitor, tx_monitor}), 0);
    chk("reset overflow", 32'(rx_overflow), 0);
    chk("reset counters", 32'({rx_byte_cnt, tx_byte_cnt}), 0);
    @(negedge pclk);
    rst_n = 1'b1;

    //          rxv rxd    arr atv atd    txr lb clr | arv ard  rl tv td   tl ovf rmon   tmon
    tbl[0]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{1, 8'hA5, 0, 0, 8'h00, 0, 0, 0,   1, 8'hA5, 1, 0, 8'h00, 0, 0, 8'hA5, 8'h00};
    tbl[2]  = '{1, 8'h3C, 0, 0, 8'h00, 0, 0, 0,   1, 8'hA5, 2, 0, 8'h00, 0, 0, 8'h3C, 8'h00};
    tbl[3]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0,   1, 8'h3C, 1, 0, 8'h00, 0, 0, 8'h3C, 8'h00};
    tbl[4]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h3C, 8'h00};
    tbl[5]  = '{0, 8'h00, 0, 1, 8'h11, 0, 0, 0,   0, 8'h00, 0, 1, 8'h11, 1, 0, 8'h3C, 8'h00};
    tbl[6]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h3C, 8'h11};
    tbl[7]  = '{1, 8'h7E, 0, 0, 8'h00, 1, 1, 0,   0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h7E, 8'h11};
    tbl[8]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 0,   0, 8'h00, 0, 1, 8'h7E, 1, 0, 8'h7E, 8'h11};
    tbl[9]  = '{0, 8'h00, 0, 0, 8'h00, 1, 1, 0,   0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h7E, 8'h7E};
    tbl[10] = '{1, 8'h99, 1, 0, 8'h00, 0, 0, 0,   1, 8'h99, 1, 0, 8'h00, 0, 0, 8'h99, 8'h7E};
    tbl[11] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0,   0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h99, 8'h7E};

    for (int i = 0; i < 12; i++) begin
      bus.rx_valid     = tbl[i].rxv;
      bus.rx_data      = tbl[i].rxd;
      bus.app_rx_ready = tbl[i].arr;
      bus.app_tx_valid = tbl[i].atv;
      bus.app_tx_data  = tbl[i].atd;
      bus.tx_ready     = tbl[i].txr;
      loopback_enable  = tbl[i].lb;
      clear_flags      = tbl[i].clr;
      step();
      t = $sformatf("tbl[%0d]", i);
      chk({t, " app_rx_valid"}, 32'(bus.app_rx_valid), 32'(tbl[i].e_arv));
      if (tbl[i].e_arv) chk({t, " app_rx_data"}, 32'(bus.app_rx_data), 32'(tbl[i].e_ard));
      chk({t, " rx_level"}, 32'(rx_level), 32'(tbl[i].e_rlvl));
      chk({t, " tx_valid"}, 32'(bus.tx_valid), 32'(tbl[i].e_tv));
      if (tbl[i].e_tv) chk({t, " tx_data"}, 32'(bus.tx_data), 32'(tbl[i].e_td));
      chk({t, " tx_level"}, 32'(tx_level), 32'(tbl[i].e_tlvl));
      chk({t, " rx_overflow"}, 32'(rx_overflow), 32'(tbl[i].e_ovf));
      chk({t, " rx_monitor"}, 32'(rx_monitor), 32'(tbl[i].e_rmon));
      chk({t, " tx_monitor"}, 32'(tx_monitor), 32'(tbl[i].e_tmon));
    end
    idle();

    // RX overflow: 17 strobes into an empty FIFO, no pops
    for (int i = 0; i < 17; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'(i);
      step();
      check_model("ovf fill");
    end
    idle();
    chk("ovf rx_level", 32'(rx_level), 16);
    chk("ovf flag set", 32'(rx_overflow), 1);
    chk("ovf head", 32'(bus.app_rx_data), 32'h00);
    clear_flags = 1'b1;
    step();
    clear_flags = 1'b0;
    chk("ovf flag cleared", 32'(rx_overflow), 0);

    // Full RX with strobe and simultaneous pop
    bus.rx_valid     = 1'b1;
    bus.rx_data      = 8'h55;
    bus.app_rx_ready = 1'b1;
    step();
    idle();
    chk("full+pop rx_level", 32'(rx_level), 16);
    chk("full+pop overflow", 32'(rx_overflow), 0);
    chk("full+pop head", 32'(bus.app_rx_data), 32'h01);
    chk("full+pop rx_monitor", 32'(rx_monitor), 32'h55);
    check_model("full+pop");

    // TX backpressure
    for (int i = 1; i <= 16; i++) begin
      bus.app_tx_valid = 1'b1;
      bus.app_tx_data  = 8'(i);
      step();
    end
    idle();
    chk("txbp app_tx_ready", 32'(bus.app_tx_ready), 0);
    chk("txbp tx_level", 32'(tx_level), 16);
    check_model("txbp full");
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("txbp drain[%0d]", i), 32'(bus.tx_data), 32'(i));
      bus.tx_ready = 1'b1;
      step();
      check_model("txbp drain");
    end
    idle();
    chk("txbp drained level", 32'(tx_level), 0);

    // Reset mid-operation: RX overflowed, then both FIFOs half full
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEE;
    step();
    idle();
    chk("pre-reset overflow", 32'(rx_overflow), 1);
    for (int i = 0; i < 8; i++) begin
      bus.app_rx_ready = 1'b1;
      bus.app_tx_valid = 1'b1;
      bus.app_tx_data  = 8'(8'hC0 + i);
      step();
    end
    idle();
    check_model("pre-reset");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst rx_level", 32'(rx_level), 0);
    chk("midrst tx_level", 32'(tx_level), 0);
    chk("midrst valids", 32'({bus.app_rx_valid, bus.tx_valid}), 0);
    chk("midrst monitors", 32'({rx_monitor, tx_monitor}), 0);
    chk("midrst overflow", 32'(rx_overflow), 0);
    @(negedge pclk);
    rst_n = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h42;
    step();
    idle();
    chk("post-reset app_rx_valid", 32'(bus.app_rx_valid), 1);
    chk("post-reset app_rx_data", 32'(bus.app_rx_data), 32'h42);
    check_model("post-reset");

    // Randomized traffic with mode switches
    for (int c = 0; c < 3000; c++) begin
      int ph;
      ph = (c / 250) % 4;
      if (c % 40 == 0) loopback_enable = ($urandom_range(0, 2) == 0);
      bus.rx_valid     = ($urandom_range(0, 3) < (ph == 0 ? 3 : 2));
      bus.rx_data      = 8'($urandom);
      bus.app_rx_ready = ($urandom_range(0, 3) < ph);
      bus.app_tx_valid = ($urandom_range(0, 1) == 1);
      bus.app_tx_data  = 8'($urandom);
      bus.tx_ready     = ($urandom_range(0, 3) < (ph == 1 ? 1 : 3));
      clear_flags      = ($urandom_range(0, 29) == 0);
      step();
      check_model("rnd");
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
